// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> datapath/memory signal bundle
// instr_count is present only when CU_INSTR_COUNT_EN is defined.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             ihit;
    logic             dhit;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             IR_EN;
    logic             PC_EN;
    logic [1:0]       PC_src;
    logic             Ext_src;
    logic             LUI_src;
    logic [2:0]       portb_src;
    logic [1:0]       RegDst;
    logic [3:0]       ALU_op;
    logic             RegWEN;
    logic [1:0]       MemtoReg;
    logic             halt;
    logic             mem_timeout;
    logic             illegal;
`ifdef CU_INSTR_COUNT_EN
    logic [CNT_W-1:0] instr_count;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    modport master (
        input  opcode, funct, zero, ihit, dhit,
`ifdef CU_INSTR_COUNT_EN
        output instr_count,
`endif
        output imemREN, dmemREN, dmemWEN, IR_EN, PC_EN, PC_src, Ext_src, LUI_src,
               portb_src, RegDst, ALU_op, RegWEN, MemtoReg, halt, mem_timeout, illegal
    );

    modport slave (
        output opcode, funct, zero, ihit, dhit,
`ifdef CU_INSTR_COUNT_EN
        input  instr_count,
`endif
        input  imemREN, dmemREN, dmemWEN, IR_EN, PC_EN, PC_src, Ext_src, LUI_src,
               portb_src, RegDst, ALU_op, RegWEN, MemtoReg, halt, mem_timeout, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS control FSM with memory watchdog
// Optional retired-instruction counter enabled by CU_INSTR_COUNT_EN.
module multicycle_control_unit #(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    multicycle_control_unit_if.master   cu
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
                           OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110,
                           OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                           OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL  = 6'b000010, FN_JR   = 6'b001000,
                           FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_SUB  = 6'b100010,
                           FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR   = 6'b100101,
                           FN_XOR = 6'b100110, FN_NOR  = 6'b100111, FN_SLT  = 6'b101010,
                           FN_SLTU = 6'b101011;
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                           ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    if (WAIT_LIMIT < 1 || CNT_W < 1) begin : g_bad_params
        $error("WAIT_LIMIT and CNT_W must be at least 1");
    end

    state_t           state;
    logic [WCW-1:0]   wait_cnt;
    logic             halt_q, timeout_q, illegal_q;
    logic             waiting;

    logic             d_ext, d_lui;
    logic [2:0]       d_portb;
    logic [1:0]       d_regdst;
    logic [3:0]       d_alu;
    logic             is_jr, is_br, is_j, is_jal, is_lw, is_sw, is_halt, is_alu, known;
    logic             br_taken;

    always_comb begin
        d_ext = 1'b0; d_lui = 1'b0; d_portb = 3'b000; d_regdst = 2'b00; d_alu = ALU_SLL;
        is_jr = 1'b0; is_br = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_lw = 1'b0;
        is_sw = 1'b0; is_halt = 1'b0; is_alu = 1'b0; known = 1'b1;
        case (cu.opcode)
            OP_RTYPE: begin
                is_jr  = (cu.funct == FN_JR);
                is_alu = (cu.funct != FN_JR);
                case (cu.funct)
                    FN_SLL:          begin d_alu = ALU_SLL; d_portb = 3'b010; end
                    FN_SRL:          begin d_alu = ALU_SRL; d_portb = 3'b010; end
                    FN_ADD, FN_ADDU: d_alu = ALU_ADD;
                    FN_SUB, FN_SUBU: d_alu = ALU_SUB;
                    FN_AND:          d_alu = ALU_AND;
                    FN_OR:           d_alu = ALU_OR;
                    FN_XOR:          d_alu = ALU_XOR;
                    FN_NOR:          d_alu = ALU_NOR;
                    FN_SLT:          d_alu = ALU_SLT;
                    FN_SLTU:         d_alu = ALU_SLTU;
                    default: ;
                endcase
            end
            OP_J:   is_j = 1'b1;
            OP_JAL: begin is_jal = 1'b1; d_regdst = 2'b10; end
            OP_BEQ, OP_BNE: begin is_br = 1'b1; d_ext = 1'b1; d_alu = ALU_SUB; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                is_alu = 1'b1; d_portb = 3'b001; d_regdst = 2'b01;
                case (cu.opcode)
                    OP_ADDI, OP_ADDIU: begin d_ext = 1'b1; d_alu = ALU_ADD; end
                    OP_SLTI:           begin d_ext = 1'b1; d_alu = ALU_SLT; end
                    OP_SLTIU:          begin d_ext = 1'b1; d_alu = ALU_SLTU; end
                    OP_ANDI:           d_alu = ALU_AND;
                    OP_ORI:            d_alu = ALU_OR;
                    OP_XORI:           d_alu = ALU_XOR;
                    default:           begin d_lui = 1'b1; d_alu = ALU_OR; end
                endcase
            end
            OP_LW, OP_SW: begin
                is_lw = (cu.opcode == OP_LW); is_sw = (cu.opcode == OP_SW);
                d_ext = 1'b1; d_portb = 3'b001; d_regdst = 2'b01; d_alu = ALU_ADD;
            end
            OP_HALT: is_halt = 1'b1;
            default: known = 1'b0;
        endcase
    end

    assign br_taken = is_br && ((cu.opcode == OP_BEQ) ? cu.zero : !cu.zero);
    assign waiting  = (state == FETCH && !cu.ihit) || (state == MEM && !cu.dhit);

    // Outputs are gated by nRST so an in-flight request drops the instant reset asserts.
    always_comb begin
        cu.imemREN = 1'b0; cu.dmemREN = 1'b0; cu.dmemWEN = 1'b0; cu.IR_EN = 1'b0;
        cu.PC_EN = 1'b0; cu.PC_src = 2'b00; cu.Ext_src = 1'b0; cu.LUI_src = 1'b0;
        cu.portb_src = 3'b000; cu.RegDst = 2'b00; cu.ALU_op = ALU_SLL; cu.RegWEN = 1'b0;
        cu.MemtoReg = 2'b00;
        cu.halt = halt_q; cu.mem_timeout = timeout_q; cu.illegal = illegal_q;
        if (nRST) begin
            if (state inside {DECODE, EXEC, MEM, WB}) begin
                cu.Ext_src = d_ext; cu.LUI_src = d_lui; cu.portb_src = d_portb;
                cu.RegDst = d_regdst; cu.ALU_op = d_alu;
            end
            case (state)
                FETCH: begin cu.imemREN = 1'b1; cu.IR_EN = cu.ihit; end
                EXEC: begin
                    if (is_br)       begin cu.PC_EN = 1'b1; cu.PC_src = br_taken ? 2'b01 : 2'b00; end
                    else if (is_j)   begin cu.PC_EN = 1'b1; cu.PC_src = 2'b10; end
                    else if (is_jr)  begin cu.PC_EN = 1'b1; cu.PC_src = 2'b11; end
                    else if (is_jal) begin
                        cu.PC_EN = 1'b1; cu.PC_src = 2'b10; cu.RegWEN = 1'b1; cu.MemtoReg = 2'b10;
                    end
                    else if (!known) cu.PC_EN = 1'b1;
                end
                MEM: begin
                    cu.dmemREN = is_lw;
                    cu.dmemWEN = is_sw;
                    cu.PC_EN   = is_sw && cu.dhit;
                end
                WB: begin
                    cu.RegWEN = 1'b1; cu.PC_EN = 1'b1;
                    cu.MemtoReg = is_lw ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // Counter saturates at the limit; the FSM keeps waiting for the hit.
            if (waiting) begin
                if (wait_cnt != WCW'(WAIT_LIMIT)) wait_cnt <= wait_cnt + WCW'(1);
                if (wait_cnt == WCW'(WAIT_LIMIT - 1)) timeout_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            case (state)
                FETCH:  if (cu.ihit) state <= DECODE;
                DECODE: state <= EXEC;
                EXEC: begin
                    if (is_halt) begin
                        halt_q <= 1'b1;
                        state  <= HALTED;
                    end else if (!known) begin
                        illegal_q <= 1'b1;
                        state     <= FETCH;
                    end else if (is_lw || is_sw) state <= MEM;
                    else if (is_alu)             state <= WB;
                    else                         state <= FETCH;
                end
                MEM:     if (cu.dhit) state <= is_lw ? WB : FETCH;
                WB:      state <= FETCH;
                default: state <= HALTED;
            endcase
        end
    end

`ifdef CU_INSTR_COUNT_EN
    logic [CNT_W-1:0] instr_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                              instr_cnt <= '0;
        else if (cu.PC_EN && state != HALTED)   instr_cnt <= instr_cnt + CNT_W'(1);
    end

    assign cu.instr_count = instr_cnt;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
    localparam int CNT_W = 4;

    localparam logic [23:0] IMEM = 24'h800000, DREN = 24'h400000, DWEN = 24'h200000,
                            IREN = 24'h100000, PCEN = 24'h080000, EXT  = 24'h010000,
                            RWEN = 24'h000020, HLT  = 24'h000004, TMO  = 24'h000002,
                            ILL  = 24'h000001;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_LW = 6'b100011, OP_SW = 6'b101011, OP_HALT = 6'b111111,
                           OP_BAD = 6'b010011;
    localparam logic [3:0] ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3;

    function automatic logic [23:0] pcsrc(input logic [1:0] v);  return {5'b0, v, 17'b0}; endfunction
    function automatic logic [23:0] portb(input logic [2:0] v);  return {9'b0, v, 12'b0}; endfunction
    function automatic logic [23:0] regdst(input logic [1:0] v); return {12'b0, v, 10'b0}; endfunction
    function automatic logic [23:0] alu(input logic [3:0] v);    return {14'b0, v, 6'b0}; endfunction
    function automatic logic [23:0] m2r(input logic [1:0] v);    return {19'b0, v, 3'b0}; endfunction

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    multicycle_control_unit_if #(.CNT_W(CNT_W)) cu();

    multicycle_control_unit #(.WAIT_LIMIT(4), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .cu   (cu.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string            name;
        logic [23:0]      val;
        bit               cnt_chk;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] flags = '0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;

    task automatic drive(input string name, input bit rn, input bit ih, input bit dh, input bit z,
                         input logic [23:0] ev, input bit chk, input logic [CNT_W-1:0] cnt);
        exp_t e;
        @(posedge CLK);
        #2;
        nRST = rn; cu.ihit = ih; cu.dhit = dh; cu.zero = z;
        cu.opcode = cur_op; cu.funct = cur_fn;
        e.name = name; e.val = ev | flags; e.cnt_chk = chk; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic step(input string name, input bit rn, input bit ih, input bit dh, input bit z,
                        input logic [23:0] ev);
        drive(name, rn, ih, dh, z, ev, 1'b0, '0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [23:0] got;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {cu.imemREN, cu.dmemREN, cu.dmemWEN, cu.IR_EN, cu.PC_EN, cu.PC_src,
                       cu.Ext_src, cu.LUI_src, cu.portb_src, cu.RegDst, cu.ALU_op,
                       cu.RegWEN, cu.MemtoReg, cu.halt, cu.mem_timeout, cu.illegal};
                n_cmp++;
                if (got !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: outputs got %h want %h", e.name, got, e.val);
                end
`ifdef CU_INSTR_COUNT_EN
                if (e.cnt_chk) begin
                    n_cmp++;
                    if (cu.instr_count !== e.cnt) begin
                        n_bad++;
                        $display("FAIL %s: instr_count got %0d want %0d", e.name, cu.instr_count, e.cnt);
                    end
                end
`endif
            end
        end
    end

    initial begin : stimulus
        logic [23:0] d_mem, d_br, d_jal, d_srl;
        d_mem = EXT | portb(3'b001) | regdst(2'b01) | alu(ALU_ADD);
        d_br  = EXT | alu(ALU_SUB);
        d_jal = regdst(2'b10);
        d_srl = portb(3'b010) | alu(ALU_SRL);
        cu.opcode = '0; cu.funct = '0; cu.zero = 1'b0; cu.ihit = 1'b0; cu.dhit = 1'b0;

        step("reset", 0, 0, 0, 0, '0);
        cur_op = OP_SW;
        step("sw_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("sw_dec",   1, 0, 0, 0, d_mem);
        step("sw_exec",  1, 0, 0, 0, d_mem);
        step("sw_mem",   1, 0, 0, 0, d_mem | DWEN);
        step("sw_reset", 0, 0, 0, 0, '0);

        cur_op = OP_ADDI;
        step("addi_f1", 1, 0, 0, 0, IMEM);
        step("addi_f2", 1, 0, 1, 0, IMEM);
        step("addi_f3", 1, 0, 0, 0, IMEM);
        step("addi_f4", 1, 1, 0, 0, IMEM | IREN);
        step("addi_dec", 1, 0, 0, 0, d_mem);
        step("addi_exec", 1, 0, 0, 0, d_mem);
        step("addi_wb",  1, 0, 0, 0, d_mem | RWEN | PCEN);

        cur_op = OP_BEQ;
        step("beq_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("beq_dec",   1, 0, 0, 1, d_br);
        step("beq_z1",    1, 0, 0, 1, d_br | PCEN | pcsrc(2'b01));
        cur_op = OP_BNE;
        step("bne_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("bne_dec",   1, 0, 0, 1, d_br);
        step("bne_z1",    1, 0, 0, 1, d_br | PCEN);
        step("bne2_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("bne2_dec",  1, 0, 0, 0, d_br);
        step("bne_z0",    1, 0, 0, 0, d_br | PCEN | pcsrc(2'b01));

        cur_op = OP_JAL;
        step("jal_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("jal_dec",   1, 0, 0, 0, d_jal);
        step("jal_exec",  1, 0, 0, 0, d_jal | PCEN | pcsrc(2'b10) | RWEN | m2r(2'b10));

        cur_op = OP_RTYPE; cur_fn = 6'b001000;
        step("jr_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("jr_dec",   1, 0, 0, 0, '0);
        step("jr_exec",  1, 0, 0, 0, PCEN | pcsrc(2'b11));
        cur_fn = 6'b000010;
        step("srl_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("srl_dec",   1, 0, 0, 0, d_srl);
        step("srl_exec",  1, 0, 0, 0, d_srl);
        step("srl_wb",    1, 0, 0, 0, d_srl | RWEN | PCEN);

        cur_op = OP_LW; cur_fn = '0;
        step("lw_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("lw_dec",   1, 0, 0, 0, d_mem);
        step("lw_exec",  1, 0, 0, 0, d_mem);
        step("lw_stall1", 1, 1, 0, 0, d_mem | DREN);
        step("lw_stall2", 1, 0, 0, 0, d_mem | DREN);
        step("lw_stall3", 1, 0, 0, 0, d_mem | DREN);
        step("lw_stall4", 1, 0, 0, 0, d_mem | DREN);
        flags = TMO;
        step("lw_hit",   1, 0, 1, 0, d_mem | DREN);
        step("lw_wb",    1, 0, 0, 0, d_mem | RWEN | PCEN | m2r(2'b01));

        cur_op = OP_BAD;
        step("bad_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("bad_dec",   1, 0, 0, 0, '0);
        step("bad_exec",  1, 0, 0, 0, PCEN);
        flags = TMO | ILL;
        cur_op = OP_HALT;
        step("halt_fetch", 1, 1, 0, 0, IMEM | IREN);
        step("halt_dec",   1, 0, 0, 0, '0);
        step("halt_exec",  1, 0, 0, 0, '0);
        flags = TMO | ILL | HLT;
        for (int i = 0; i < 20; i++) step("halted", 1, i[0], ~i[0], 1, '0);

`ifdef CU_INSTR_COUNT_EN
        flags = '0;
        drive("cnt_reset", 0, 0, 0, 0, '0, 1'b1, '0);
        cur_op = OP_J;
        for (int i = 0; i < 17; i++) begin
            step("j_fetch", 1, 1, 0, 0, IMEM | IREN);
            step("j_dec",   1, 0, 0, 0, '0);
            step("j_exec",  1, 0, 0, 0, PCEN | pcsrc(2'b10));
        end
        drive("cnt_wrap", 1, 0, 0, 0, IMEM, 1'b1, CNT_W'(1));
`endif

        repeat (4) @(negedge CLK);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: pending got %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
